// File: rtl/tl_ul_data_mem.sv
// TileLink-UL style memory slave: channel A requests, channel D responses,
// one outstanding request with a programmable access latency and response backpressure.
module tl_ul_data_mem #(
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  logic [2:0]        a_opcode_i,
    input  logic [ADDR_W-1:0] a_address_i,
    input  logic [31:0]       a_data_i,
    output logic              d_valid_o,
    input  logic              d_ready_i,
    output logic [2:0]        d_opcode_o,
    output logic [31:0]       d_data_o,
    output logic              d_denied_o
);

    localparam int         IDX_W       = $clog2(DEPTH);
    localparam logic [2:0] OP_GET      = 3'b100;
    localparam logic [2:0] OP_PUT      = 3'b000;
    localparam logic [2:0] OP_ACK_DATA = 3'b001;
    localparam logic [2:0] OP_ACK      = 3'b000;
    localparam logic [3:0] LAT_INIT    = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        d_opcode_q, d_opcode_d;
    logic [31:0]       d_data_q, d_data_d;
    logic              d_denied_q, d_denied_d;

    logic [31:0]       mem_q [DEPTH];

    logic              accept_s;
    logic              access_s;
    logic              denied_s;
    logic              wr_en_s;
    logic [ADDR_W-3:0] word_s;
    logic [IDX_W-1:0]  idx_s;

    assign word_s    = addr_q[ADDR_W-1:2];
    assign idx_s     = addr_q[IDX_W+1:2];
    assign a_ready_o = (state_q == IDLE) && !reset;
    assign accept_s  = a_valid_i && a_ready_o;
    assign access_s  = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign denied_s  = (addr_q[1:0] != 2'b00)
                    || (32'(word_s) >= 32'(DEPTH))
                    || ((op_q != OP_GET) && (op_q != OP_PUT));
    // Reset low is required so an abort in ACCESS can never land a write.
    assign wr_en_s   = access_s && !denied_s && (op_q == OP_PUT) && !reset;

    assign d_valid_o  = (state_q == RESP);
    assign d_opcode_o = d_opcode_q;
    assign d_data_o   = d_data_q;
    assign d_denied_o = d_denied_q;

    // Next-state logic: request capture, latency countdown and response formation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        d_opcode_d = d_opcode_q;
        d_data_d   = d_data_q;
        d_denied_d = d_denied_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    op_d    = a_opcode_i;
                    addr_d  = a_address_i;
                    wdata_d = a_data_i;
                    cnt_d   = LAT_INIT;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    d_opcode_d = (op_q == OP_GET) ? OP_ACK_DATA : OP_ACK;
                    d_denied_d = denied_s;
                    d_data_d   = ((op_q == OP_GET) && !denied_s) ? mem_q[idx_s] : 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (d_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers; reset aborts any request in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            op_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= 32'h0000_0000;
            d_opcode_q <= 3'b000;
            d_data_q   <= 32'h0000_0000;
            d_denied_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            d_opcode_q <= d_opcode_d;
            d_data_q   <= d_data_d;
            d_denied_q <= d_denied_d;
        end
    end

    // Word storage, intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[idx_s] <= wdata_q;
        end
    end

endmodule
